// File: rtl/preadd_pkg.sv
// Shared constants for the dual A/D pre-adder sequencer: opcodes, FSM state
// encoding and the INMODE width.
package preadd_pkg;

   localparam int INMODE_W = 4;

   localparam logic [2:0] OP_PASS_A    = 3'd0;
   localparam logic [2:0] OP_D_PLUS_A  = 3'd1;
   localparam logic [2:0] OP_D_MINUS_A = 3'd2;
   localparam logic [2:0] OP_PASS_D    = 3'd3;
   localparam logic [2:0] OP_NEG_A     = 3'd4;
   localparam logic [2:0] OP_ZERO      = 3'd5;
   localparam logic [2:0] OP_FLUSH     = 3'd6;
   localparam logic [2:0] OP_RSVD      = 3'd7;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] A2   = 3'd1;
   localparam logic [2:0] PRE  = 3'd2;
   localparam logic [2:0] RES  = 3'd3;
   localparam logic [2:0] FLSH = 3'd4;

   // Opcodes 0..5 drive the pre-adder; 6 and 7 never touch the operand registers.
   function automatic logic is_compute(input logic [2:0] op);
      return (op <= OP_ZERO);
   endfunction

endpackage

// File: rtl/preadd_inmode_dec.sv
// Opcode to INMODE[3:1] decoder; legal_o is high only for pre-adder compute ops.
module preadd_inmode_dec
   import preadd_pkg::*;
(
   input  logic [2:0] op_i,
   output logic [2:0] mode_o,
   output logic       legal_o
);

   // mode_o = {in3, in2, in1}: in1 gates A to zero, in2 enables D, in3 negates A.
   always_comb begin
      mode_o  = 3'b000;
      legal_o = 1'b1;
      case (op_i)
         OP_PASS_A:    mode_o = 3'b000;
         OP_D_PLUS_A:  mode_o = 3'b010;
         OP_D_MINUS_A: mode_o = 3'b110;
         OP_PASS_D:    mode_o = 3'b011;
         OP_NEG_A:     mode_o = 3'b100;
         OP_ZERO:      mode_o = 3'b001;
         default: begin
            mode_o  = 3'b000;
            legal_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/preadd_ctrl.sv
// Sequencer for the dual A/D pre-adder: accepts one op at a time, steps the
// register enables, holds INMODE through the result handshake and issues flushes.
module preadd_ctrl
   import preadd_pkg::*;
#(
   parameter int AREG  = 2,
   parameter int ADREG = 1,
   parameter int DREG  = 1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic       cmd_a1,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       err,
   output logic       in0,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       CEA1,
   output logic       CEA2,
   output logic       CED,
   output logic       CEAD,
   output logic       RSTA,
   output logic       RSTD,
   output logic       RSTAD
);

   logic [2:0] state_q, state_d;
   logic [2:0] op_q, op_d;
   logic       a1_q, a1_d;
   logic       err_q, err_d;
   logic [2:0] mode_s;
   logic       legal_s;
   logic       accept_s;
   logic       cap_s;
   logic       hold_s;

   preadd_inmode_dec u_dec (
      .op_i    (op_q),
      .mode_o  (mode_s),
      .legal_o (legal_s)
   );

   assign cmd_ready = (state_q == IDLE) && !rst;
   assign accept_s  = cmd_valid && cmd_ready;
   assign cap_s     = accept_s && is_compute(cmd_op);
   assign hold_s    = ((state_q == PRE) || (state_q == RES)) && legal_s;

   // Next-state, command latch and reserved-opcode error decode.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a1_d    = a1_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               op_d = cmd_op;
               a1_d = cmd_a1;
               if (is_compute(cmd_op)) begin
                  state_d = (AREG == 2) ? A2 : PRE;
               end else if (cmd_op == OP_FLUSH) begin
                  state_d = FLSH;
               end else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         A2:   state_d = PRE;
         PRE:  state_d = RES;
         RES: begin
            if (res_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RES;
            end
         end
         FLSH:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latched-command registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= 3'd0;
         a1_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a1_q    <= a1_d;
         err_q   <= err_d;
      end
   end

   // Operands are captured at the accept edge, so CEA1/CED are Mealy on the handshake.
   assign CEA1 = cap_s;
   assign CED  = cap_s && (DREG != 0);
   assign CEA2 = (state_q == A2);
   assign CEAD = (state_q == PRE) && (ADREG != 0);

   assign {in3, in2, in1} = hold_s ? mode_s : 3'b000;
   assign in0             = hold_s && (AREG == 2) && a1_q;

   assign res_valid = (state_q == RES);
   assign err       = err_q;

   // Reset is forwarded combinationally so the datapath clears in the same cycle.
   assign RSTA  = rst || (state_q == FLSH);
   assign RSTD  = rst || (state_q == FLSH);
   assign RSTAD = rst || (state_q == FLSH);

endmodule

// File: tb/tb_preadd_ctrl.sv
// Bench for preadd_ctrl: an AREG=2 and an AREG=1 instance, each driving a
// behavioural pre-adder datapath whose out3 is scored against queued results.
module tb_preadd_ctrl;

   logic clk, rst;
   logic [24:0] a_in, d_in;

   logic cmd_valid, cmd_ready, cmd_a1, res_valid, res_ready, err;
   logic [2:0] cmd_op;
   logic in0, in1, in2, in3, CEA1, CEA2, CED, CEAD, RSTA, RSTD, RSTAD;

   logic b_cmd_valid, b_cmd_ready, b_cmd_a1, b_res_valid, b_res_ready, b_err;
   logic [2:0] b_cmd_op;
   logic b_in0, b_in1, b_in2, b_in3, b_CEA1, b_CEA2, b_CED, b_CEAD, b_RSTA, b_RSTD, b_RSTAD;

   logic [24:0] sb_q[$];
   logic [24:0] b_sb_q[$];
   logic [24:0] exp_v;
   int errors, checks, n;

   preadd_ctrl #(.AREG(2), .ADREG(1), .DREG(1)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a1(cmd_a1), .res_valid(res_valid), .res_ready(res_ready), .err(err),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3), .CEA1(CEA1), .CEA2(CEA2), .CED(CED),
      .CEAD(CEAD), .RSTA(RSTA), .RSTD(RSTD), .RSTAD(RSTAD)
   );

   preadd_ctrl #(.AREG(1), .ADREG(1), .DREG(1)) u_dut_b (
      .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
      .cmd_a1(b_cmd_a1), .res_valid(b_res_valid), .res_ready(b_res_ready), .err(b_err),
      .in0(b_in0), .in1(b_in1), .in2(b_in2), .in3(b_in3), .CEA1(b_CEA1), .CEA2(b_CEA2), .CED(b_CED),
      .CEAD(b_CEAD), .RSTA(b_RSTA), .RSTD(b_RSTD), .RSTAD(b_RSTAD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural datapath for the AREG=2 instance.
   logic [24:0] a1_m, a2_m, d_m, ad_m, at_m, pre_m;
   always_comb begin
      at_m  = in1 ? 25'd0 : (in0 ? a1_m : a2_m);
      pre_m = (in2 ? d_m : 25'd0) + (in3 ? (25'd0 - at_m) : at_m);
   end
   always_ff @(posedge clk) begin
      if (RSTA) begin a1_m <= 25'd0; a2_m <= 25'd0; end
      else begin
         if (CEA1) a1_m <= a_in;
         if (CEA2) a2_m <= a1_m;
      end
      if (RSTD) d_m <= 25'd0; else if (CED) d_m <= d_in;
      if (RSTAD) ad_m <= 25'd0; else if (CEAD) ad_m <= pre_m;
   end

   // Behavioural datapath for the AREG=1 instance (single A register).
   logic [24:0] b_a1_m, b_d_m, b_ad_m, b_at_m, b_pre_m;
   always_comb begin
      b_at_m  = b_in1 ? 25'd0 : b_a1_m;
      b_pre_m = (b_in2 ? b_d_m : 25'd0) + (b_in3 ? (25'd0 - b_at_m) : b_at_m);
   end
   always_ff @(posedge clk) begin
      if (b_RSTA) b_a1_m <= 25'd0; else if (b_CEA1) b_a1_m <= a_in;
      if (b_RSTD) b_d_m <= 25'd0; else if (b_CED) b_d_m <= d_in;
      if (b_RSTAD) b_ad_m <= 25'd0; else if (b_CEAD) b_ad_m <= b_pre_m;
   end

   function automatic logic [24:0] exp_res(input logic [2:0] op, input logic [24:0] a, input logic [24:0] d);
      case (op)
         3'd0: return a;
         3'd1: return d + a;
         3'd2: return d - a;
         3'd3: return d;
         3'd4: return 25'd0 - a;
         default: return 25'd0;
      endcase
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if ({cmd_ready, b_cmd_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", {cmd_ready, b_cmd_ready}); end
      checks++; if ({RSTA, RSTD, RSTAD} !== 3'b111) begin errors++; $display("FAIL rst_flush: got %b expected 111", {RSTA, RSTD, RSTAD}); end
      rst = 1'b0;
      @(negedge clk); #1;
      checks++; if ({cmd_ready, res_valid, err} !== 3'b100) begin errors++; $display("FAIL rst_hs: got %b expected 100", {cmd_ready, res_valid, err}); end
      checks++; if ({in3, in2, in1, in0, CEA1, CEA2, CED, CEAD, RSTA, RSTD, RSTAD} !== 11'd0) begin errors++; $display("FAIL rst_ctl: got %b expected 0", {in3, in2, in1, in0, CEA1, CEA2, CED, CEAD, RSTA, RSTD, RSTAD}); end
      checks++; if ({b_cmd_ready, b_res_valid, b_err} !== 3'b100) begin errors++; $display("FAIL rst_b: got %b expected 100", {b_cmd_ready, b_res_valid, b_err}); end
   endtask

   task automatic test_d_plus_a;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a1 = 1'b0; a_in = 25'd5; d_in = 25'd7; #1;
      checks++; if ({cmd_ready, CEA1, CED, CEA2, CEAD} !== 5'b11100) begin errors++; $display("FAIL dpa_accept: got %b expected 11100", {cmd_ready, CEA1, CED, CEA2, CEAD}); end
      sb_q.push_back(exp_res(3'd1, 25'd5, 25'd7));
      @(negedge clk);
      cmd_valid = 1'b0; a_in = 25'h0ABCDE; d_in = 25'h012345; #1;
      checks++; if ({cmd_ready, CEA1, CED, CEA2, CEAD, res_valid} !== 6'b000100) begin errors++; $display("FAIL dpa_a2: got %b expected 000100", {cmd_ready, CEA1, CED, CEA2, CEAD, res_valid}); end
      @(negedge clk); #1;
      checks++; if ({CEA2, CEAD, in3, in2, in1, in0, res_valid} !== 7'b0101000) begin errors++; $display("FAIL dpa_pre: got %b expected 0101000", {CEA2, CEAD, in3, in2, in1, in0, res_valid}); end
      @(negedge clk); #1;
      checks++; if ({res_valid, CEAD, in3, in2, in1} !== 5'b10010) begin errors++; $display("FAIL dpa_res: got %b expected 10010", {res_valid, CEAD, in3, in2, in1}); end
      exp_v = sb_q.pop_front();
      checks++; if (ad_m !== exp_v) begin errors++; $display("FAIL dpa_out3: got %0h expected %0h", ad_m, exp_v); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0; #1;
      checks++; if ({res_valid, cmd_ready, in2} !== 3'b010) begin errors++; $display("FAIL dpa_done: got %b expected 010", {res_valid, cmd_ready, in2}); end
   endtask

   task automatic test_d_minus_a;
      @(negedge clk);
      b_cmd_valid = 1'b1; b_cmd_op = 3'd2; b_cmd_a1 = 1'b0; a_in = 25'd9; d_in = 25'd4; #1;
      checks++; if ({b_cmd_ready, b_CEA1, b_CED} !== 3'b111) begin errors++; $display("FAIL dma_accept: got %b expected 111", {b_cmd_ready, b_CEA1, b_CED}); end
      b_sb_q.push_back(exp_res(3'd2, 25'd9, 25'd4));
      @(negedge clk);
      b_cmd_valid = 1'b0; #1;
      checks++; if ({b_CEA2, b_CEAD, b_in3, b_in2, b_in1, b_in0, b_res_valid} !== 7'b0111000) begin errors++; $display("FAIL dma_pre: got %b expected 0111000", {b_CEA2, b_CEAD, b_in3, b_in2, b_in1, b_in0, b_res_valid}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++; if ({b_res_valid, b_in3, b_in2, b_in1, b_cmd_ready} !== 5'b11100) begin errors++; $display("FAIL dma_hold%0d: got %b expected 11100", i, {b_res_valid, b_in3, b_in2, b_in1, b_cmd_ready}); end
      end
      exp_v = b_sb_q.pop_front();
      checks++; if (b_ad_m !== exp_v) begin errors++; $display("FAIL dma_out3: got %0h expected %0h", b_ad_m, exp_v); end
      b_res_ready = 1'b1;
      @(negedge clk);
      b_res_ready = 1'b0; #1;
      checks++; if ({b_res_valid, b_cmd_ready, b_in3} !== 3'b010) begin errors++; $display("FAIL dma_done: got %b expected 010", {b_res_valid, b_cmd_ready, b_in3}); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a1 = 1'b0; a_in = 25'd77; d_in = 25'd3; #1;
      checks++; if ({cmd_ready, CEA1} !== 2'b11) begin errors++; $display("FAIL b2b_acc1: got %b expected 11", {cmd_ready, CEA1}); end
      sb_q.push_back(exp_res(3'd3, 25'd77, 25'd3));
      @(negedge clk);
      cmd_op = 3'd4; a_in = 25'd2; d_in = 25'd50; #1;
      n = 0;
      while (res_valid !== 1'b1 && n < 10) begin
         checks++; if ({cmd_ready, CEA1} !== 2'b00) begin errors++; $display("FAIL b2b_busy: got %b expected 00", {cmd_ready, CEA1}); end
         @(negedge clk); #1; n++;
      end
      checks++; if (n !== 2) begin errors++; $display("FAIL b2b_lat1: got %0d expected 2", n); end
      exp_v = sb_q.pop_front();
      checks++; if ({cmd_ready, ad_m} !== {1'b0, exp_v}) begin errors++; $display("FAIL b2b_res1: got %0h expected %0h", {cmd_ready, ad_m}, {1'b0, exp_v}); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0; #1;
      checks++; if ({cmd_ready, CEA1, res_valid} !== 3'b110) begin errors++; $display("FAIL b2b_acc2: got %b expected 110", {cmd_ready, CEA1, res_valid}); end
      sb_q.push_back(exp_res(3'd4, 25'd2, 25'd50));
      @(negedge clk);
      cmd_valid = 1'b0; #1;
      n = 0;
      while (res_valid !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
      checks++; if (n !== 2) begin errors++; $display("FAIL b2b_lat2: got %0d expected 2", n); end
      exp_v = sb_q.pop_front();
      checks++; if (ad_m !== exp_v) begin errors++; $display("FAIL b2b_res2: got %0h expected %0h", ad_m, exp_v); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reserved;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd7; a_in = 25'd11; d_in = 25'd13; #1;
      checks++; if ({cmd_ready, CEA1, CED, err} !== 4'b1000) begin errors++; $display("FAIL rsv_accept: got %b expected 1000", {cmd_ready, CEA1, CED, err}); end
      @(negedge clk);
      cmd_valid = 1'b0; #1;
      checks++; if ({err, cmd_ready, CEA2, CEAD, res_valid, RSTA} !== 6'b110000) begin errors++; $display("FAIL rsv_err: got %b expected 110000", {err, cmd_ready, CEA2, CEAD, res_valid, RSTA}); end
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd5; #1;
      checks++; if ({err, CEA1, CED} !== 3'b011) begin errors++; $display("FAIL rsv_pulse: got %b expected 011", {err, CEA1, CED}); end
      sb_q.push_back(exp_res(3'd5, 25'd11, 25'd13));
      @(negedge clk);
      cmd_valid = 1'b0; #1;
      n = 0;
      while (res_valid !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
      checks++; if (n !== 2) begin errors++; $display("FAIL zero_lat: got %0d expected 2", n); end
      exp_v = sb_q.pop_front();
      checks++; if (ad_m !== exp_v) begin errors++; $display("FAIL zero_out3: got %0h expected %0h", ad_m, exp_v); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_flush;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd6; #1;
      checks++; if ({cmd_ready, CEA1, CED, RSTA} !== 4'b1000) begin errors++; $display("FAIL fl_accept: got %b expected 1000", {cmd_ready, CEA1, CED, RSTA}); end
      @(negedge clk);
      cmd_valid = 1'b0; #1;
      checks++; if ({RSTA, RSTD, RSTAD, res_valid, cmd_ready, err} !== 6'b111000) begin errors++; $display("FAIL fl_pulse: got %b expected 111000", {RSTA, RSTD, RSTAD, res_valid, cmd_ready, err}); end
      @(negedge clk); #1;
      checks++; if ({RSTA, RSTD, RSTAD, res_valid, cmd_ready} !== 5'b00001) begin errors++; $display("FAIL fl_after: got %b expected 00001", {RSTA, RSTD, RSTAD, res_valid, cmd_ready}); end
   endtask

   task automatic test_rst_in_pre;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a1 = 1'b0; a_in = 25'd1; d_in = 25'd1; #1;
      sb_q.push_back(exp_res(3'd1, 25'd1, 25'd1));
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1; #1;
      checks++; if ({CEAD, RSTA, RSTD, RSTAD, cmd_ready} !== 5'b11110) begin errors++; $display("FAIL rp_rstcyc: got %b expected 11110", {CEAD, RSTA, RSTD, RSTAD, cmd_ready}); end
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0; #1;
      checks++; if ({res_valid, cmd_ready, CEAD, in2, RSTA} !== 5'b01000) begin errors++; $display("FAIL rp_idle: got %b expected 01000", {res_valid, cmd_ready, CEAD, in2, RSTA}); end
      checks++; if (ad_m !== 25'd0) begin errors++; $display("FAIL rp_cleared: got %0h expected 0", ad_m); end
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a1 = 1'b1; a_in = 25'd6; d_in = 25'd9; #1;
      sb_q.push_back(exp_res(3'd0, 25'd6, 25'd9));
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if ({in0, in1, in2, in3, CEAD} !== 5'b10001) begin errors++; $display("FAIL rp_pre: got %b expected 10001", {in0, in1, in2, in3, CEAD}); end
      @(negedge clk); #1;
      exp_v = sb_q.pop_front();
      checks++; if ({res_valid, ad_m} !== {1'b1, exp_v}) begin errors++; $display("FAIL rp_res: got %0h expected %0h", {res_valid, ad_m}, {1'b1, exp_v}); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0; #1;
      checks++; if ({res_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL rp_done: got %b expected 01", {res_valid, cmd_ready}); end
   endtask

   initial begin
      errors = 0; checks = 0;
      rst = 1'b1; a_in = 25'd0; d_in = 25'd0;
      cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a1 = 1'b0; res_ready = 1'b0;
      b_cmd_valid = 1'b0; b_cmd_op = 3'd0; b_cmd_a1 = 1'b0; b_res_ready = 1'b0;
      test_reset;
      test_d_plus_a;
      test_d_minus_a;
      test_back_to_back;
      test_reserved;
      test_flush;
      test_rst_in_pre;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/preadd_ctrl.md
# preadd_ctrl

Sequencer for the dual A/D pre-adder datapath. Accepts one pre-adder operation at a time over a valid/ready command port and captures the operands. It then steps the A1/A2, D and AD register enables. It holds the INMODE bits (in0..in3) stable while the result settles and presents a result-valid handshake aligned to out3. It also issues flush pulses to the datapath register resets. The controller sits between the DSP-slice control logic and the pre-adder block, and drives all of that block's dynamic control pins.

## Interface
Parameters:
- AREG, 2, number of A pipeline registers in use (legal: 1, 2); must match the pre-adder's sel1_A_p/sel2_A_p configuration
- ADREG, 1, AD register in use (0/1); when 0, CEAD is never asserted
- DREG, 1, D register in use (0/1); when 0, upstream holds D stable from accept until the result handshake

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept (IDLE only)
- cmd_op  in  3  operation code (see Operation)
- cmd_a1  in  1  select A1 instead of A2 into the pre-adder (drives in0; meaningful only when AREG=2)
- res_valid  out  1  out3 of the datapath holds the result
- res_ready  in  1  consumer takes result
- err  out  1  one-cycle pulse on an accepted reserved opcode
- in0, in1, in2, in3  out  1 each  INMODE[0..3] to the pre-adder
- CEA1, CEA2, CED, CEAD  out  1 each  clock enables to the datapath
- RSTA, RSTD, RSTAD  out  1 each  resets to the datapath registers

## Operation
- Opcodes and pre-adder result:
  - 0 PASS_A: in1=0, in2=0, in3=0, result A
  - 1 D_PLUS_A: in1=0, in2=1, in3=0, result D+A
  - 2 D_MINUS_A: in1=0, in2=1, in3=1, result D−A
  - 3 PASS_D: in1=1, in2=1, in3=0, result D
  - 4 NEG_A: in1=0, in2=0, in3=1, result −A
  - 5 ZERO: in1=1, in2=0, in3=0, result 0
  - 6 FLUSH
  - 7 reserved
- Arithmetic is 25-bit modulo; the controller does not flag overflow.
- Accept is the cycle with cmd_valid && cmd_ready. On an accepted compute op (0–5), CEA1 and CED assert in that same cycle as Mealy outputs, so operands are captured at the accept edge. The controller latches op and cmd_a1 at that edge.
- States:
  - IDLE: cmd_ready=1; all INMODE and CE outputs are 0 except the Mealy CEs. Compute op → A2 if AREG=2, otherwise PRE. FLUSH → FLSH. Op 7 → stays IDLE, err=1 next cycle, no CE.
  - A2: CEA2=1 for one cycle → PRE.
  - PRE: INMODE driven from the latched op; in0=cmd_a1 if AREG=2, else 0. CEAD=ADREG. → RES.
  - RES: res_valid=1, INMODE held. When res_ready=1 → IDLE.
  - FLSH: RSTA=RSTD=RSTAD=1 for one cycle → IDLE, no res_valid.
- rst=1 forces RSTA, RSTD and RSTAD high combinationally in the same cycle.
- Reset values, effective from the edge with rst=1: state IDLE; cmd_ready=0 while rst is high, then 1; res_valid, err, in0..in3, CEA1, CEA2, CED and CEAD all 0.

## Timing
- Accept at edge T. PRE occupies cycle T+AREG; res_valid rises at cycle T+AREG+1. Latency is 2 cycles for AREG=1 and 3 cycles for AREG=2.
- INMODE is stable from PRE until the edge at which res_ready is sampled high in RES.
- Next accept is possible no earlier than the cycle after the RES handshake. cmd_ready is 0 in A2, PRE, RES and FLSH.
- res_valid stays high until res_ready; consumer backpressure is unbounded.
- rst in any state: next cycle is IDLE, the pending result is discarded and res_valid=0. The datapath registers clear through RSTA/RSTD/RSTAD.
- err and the accept of op 7 do not block: cmd_ready remains 1.
- cmd_valid held high with no accept (non-IDLE state) causes no side effect.

## Structure
- Package preadd_pkg holds:
  - opcode localparams (OP_PASS_A … OP_RSVD)
  - state encoding localparams (IDLE, A2, PRE, RES, FLSH)
  - inmode width constant
- One sub-module, preadd_inmode_dec: combinational op[2:0] → {in3,in2,in1} plus a legal flag. The FSM instantiates it on the latched op.
- The FSM, Mealy CE logic and err register live in preadd_ctrl.

## Test plan
- AREG=2, ADREG=1: accept D_PLUS_A with A=5, D=7, cmd_a1=0 at T → CEA1=CED=1 at T, CEA2 at T+1, CEAD and in2=1/in3=0 at T+2, res_valid at T+3 with out3=12.
- AREG=1: accept D_MINUS_A with A=9, D=4 → res_valid at T+2, out3=−5 (0x1FFFFFB); in3=1 held for 3 cycles while res_ready is held low.
- Back-to-back: PASS_D (D=3) then NEG_A (A=2) with cmd_valid held high → second accept exactly one cycle after the first RES handshake; results 3 and −2; cmd_ready low in between.
- FLUSH accepted → RSTA=RSTD=RSTAD=1 for exactly one cycle, no res_valid, cmd_ready back to 1 the following cycle.
- Opcode 7 → err pulses one cycle, no CE asserted, state stays IDLE; the following ZERO op returns 0.
- rst asserted in PRE → the next cycle is IDLE with res_valid=0; RSTA/RSTD/RSTAD are high during the rst cycle; a new command completes normally afterwards.
